// File: rtl/convol_stream_source.sv
// Streaming front end for a convolution kernel: buffers framed samples, feeds them
// to the kernel one per cycle, appends NUM_TAPS-1 zero samples per frame, and owns the tap registers.
module convol_stream_source #(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int NUM_TAPS    = 8,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           s_data,
    input  logic                            s_valid,
    input  logic                            s_last,
    output logic                            s_ready,
    input  logic                            coeff_wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0]     coeff_wr_addr,
    input  logic [COEFF_WIDTH-1:0]          coeff_wr_data,
    output logic                            coeff_wr_err,
    output logic [DATA_WIDTH-1:0]           input_data,
    output logic                            enable,
    output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    localparam int ADDR_W = $clog2(NUM_TAPS);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int CNT_W  = ADDR_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } state_t;

    state_t                  state_r;
    logic [DATA_WIDTH:0]     mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [LVL_W-1:0]        level_r;
    logic [LVL_W-1:0]        level_next_s;
    logic                    ready_r;
    logic [CNT_W-1:0]        flush_cnt_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic                    enable_r;
    logic                    busy_r;
    logic                    err_r;
    logic [COEFF_WIDTH-1:0]  taps_r [NUM_TAPS];
    logic                    push_s;
    logic                    pop_s;
    logic                    wr_ok_s;
    logic [DATA_WIDTH:0]     head_s;

    // FIFO entries are {data, last}; the head is popped only while not flushing.
    assign push_s  = s_valid && ready_r;
    assign pop_s   = ((state_r == IDLE) || (state_r == STREAM)) && (level_r != '0);
    assign head_s  = mem_r[rd_ptr_r];
    assign wr_ok_s = coeff_wr_en && (state_r == IDLE) &&
                     ({1'b0, coeff_wr_addr} < (ADDR_W+1)'(NUM_TAPS));

    // Next FIFO occupancy from push/pop.
    always_comb begin
        level_next_s = level_r;
        if (push_s && !pop_s) begin
            level_next_s = level_r + LVL_W'(1);
        end else if (pop_s && !push_s) begin
            level_next_s = level_r - LVL_W'(1);
        end else begin
            level_next_s = level_r;
        end
    end

    // Sample storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {s_data, s_last};
        end
    end

    // FIFO pointers, occupancy and registered ready (low while in reset).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            ready_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_next_s;
            ready_r <= (level_next_s < LVL_W'(FIFO_DEPTH));
        end
    end

    // Frame sequencer: forwards samples, then emits the zero tail before returning to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            flush_cnt_r <= '0;
            data_r      <= '0;
            enable_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE, STREAM: begin
                    if (pop_s) begin
                        data_r   <= head_s[DATA_WIDTH:1];
                        enable_r <= 1'b1;
                        busy_r   <= 1'b1;
                        if (head_s[0]) begin
                            state_r     <= FLUSH;
                            flush_cnt_r <= CNT_W'(NUM_TAPS - 1);
                        end else begin
                            state_r <= STREAM;
                        end
                    end else begin
                        enable_r <= 1'b0;
                    end
                end
                FLUSH: begin
                    if (flush_cnt_r != '0) begin
                        data_r      <= '0;
                        enable_r    <= 1'b1;
                        flush_cnt_r <= flush_cnt_r - CNT_W'(1);
                    end else begin
                        enable_r <= 1'b0;
                        busy_r   <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    enable_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    // Tap registers are writable only while IDLE; any other write raises a one-cycle error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                taps_r[k] <= '0;
            end
            err_r <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                if (wr_ok_s && (coeff_wr_addr == ADDR_W'(k))) begin
                    taps_r[k] <= coeff_wr_data;
                end
            end
            err_r <= coeff_wr_en && !wr_ok_s;
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_pack
        assign coeff[g*COEFF_WIDTH +: COEFF_WIDTH] = taps_r[g];
    end

    assign s_ready      = ready_r;
    assign fifo_level   = level_r;
    assign input_data   = data_r;
    assign enable       = enable_r;
    assign busy         = busy_r;
    assign coeff_wr_err = err_r;

endmodule

// File: tb/tb_convol_stream_source.sv
// Directed bench for convol_stream_source: vector tables plus hand-built frame sequences.
module tb_convol_stream_source;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [15:0]  s_data;
    logic         s_valid, s_last, s_ready;
    logic         coeff_wr_en;
    logic [2:0]   coeff_wr_addr;
    logic [15:0]  coeff_wr_data;
    logic         coeff_wr_err;
    logic [15:0]  input_data;
    logic         enable, busy;
    logic [127:0] coeff;
    logic [3:0]   fifo_level;

    logic [15:0]  sm_s_data;
    logic         sm_s_valid, sm_s_last, sm_s_ready;
    logic         sm_wr_en;
    logic [2:0]   sm_wr_addr;
    logic [15:0]  sm_wr_data;
    logic         sm_wr_err;
    logic [15:0]  sm_input_data;
    logic         sm_enable, sm_busy;
    logic [95:0]  sm_coeff;
    logic [3:0]   sm_fifo_level;

    convol_stream_source dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .coeff_wr_en(coeff_wr_en), .coeff_wr_addr(coeff_wr_addr), .coeff_wr_data(coeff_wr_data),
        .coeff_wr_err(coeff_wr_err), .input_data(input_data), .enable(enable),
        .coeff(coeff), .busy(busy), .fifo_level(fifo_level)
    );

    convol_stream_source #(.NUM_TAPS(6)) dut_sm (
        .clk(clk), .reset(reset),
        .s_data(sm_s_data), .s_valid(sm_s_valid), .s_last(sm_s_last), .s_ready(sm_s_ready),
        .coeff_wr_en(sm_wr_en), .coeff_wr_addr(sm_wr_addr), .coeff_wr_data(sm_wr_data),
        .coeff_wr_err(sm_wr_err), .input_data(sm_input_data), .enable(sm_enable),
        .coeff(sm_coeff), .busy(sm_busy), .fifo_level(sm_fifo_level)
    );

    int checks = 0;
    int failures = 0;

    logic [15:0] got_q[$];
    logic [3:0]  lvl_q[$];
    int          stall_cnt = 0;

    // Record every kernel-side sample, FIFO level while busy, and back-pressure events.
    always @(negedge clk) begin
        if (enable) got_q.push_back(input_data);
        if (busy) lvl_q.push_back(fifo_level);
        if (s_valid && !s_ready && !reset) stall_cnt = stall_cnt + 1;
    end

    typedef struct {
        logic [2:0]  a;
        logic [15:0] d;
        logic [15:0] exp_tap;
    } cw_t;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        l;
        logic        en;
        logic [15:0] q;
        logic        bz;
    } gap_t;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        int n = 0;
        s_data = d; s_last = l; s_valid = 1'b1;
        while (!s_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        chk("send_ready", 128'(n < 100), 128'd1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 300) begin @(posedge clk); #1; n++; end
        chk(nm, 128'(busy), 128'd0);
    endtask

    task automatic cmp_stream(input string nm, input int base, input logic [15:0] exp[$]);
        chk({nm, "_len"}, 128'(got_q.size() - base), 128'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got_q.size()) chk({nm, "_data"}, 128'(got_q[base + i]), 128'(exp[i]));
        end
    endtask

    initial begin
        cw_t         ct[8];
        gap_t        gt[14];
        logic [15:0] exp_q[$];
        int          base;
        int          lbase;
        int          sbase;
        int          maxl;
        int          n;

        ct[0] = '{3'd0, 16'd1, 16'd1};
        ct[1] = '{3'd1, 16'd2, 16'd2};
        ct[2] = '{3'd2, 16'd3, 16'd3};
        ct[3] = '{3'd3, 16'd4, 16'd4};
        ct[4] = '{3'd4, 16'd5, 16'd5};
        ct[5] = '{3'd5, 16'd6, 16'd6};
        ct[6] = '{3'd6, 16'd7, 16'd7};
        ct[7] = '{3'd7, 16'd8, 16'd8};

        // samples 1, 2, two idle cycles, 3 (last): expected kernel side after each edge
        gt[0]  = '{1'b1, 16'd1, 1'b0, 1'b0, 16'd0, 1'b0};
        gt[1]  = '{1'b1, 16'd2, 1'b0, 1'b1, 16'd1, 1'b1};
        gt[2]  = '{1'b0, 16'd0, 1'b0, 1'b1, 16'd2, 1'b1};
        gt[3]  = '{1'b0, 16'd0, 1'b0, 1'b0, 16'd2, 1'b1};
        gt[4]  = '{1'b1, 16'd3, 1'b1, 1'b0, 16'd2, 1'b1};
        gt[5]  = '{1'b0, 16'd0, 1'b0, 1'b1, 16'd3, 1'b1};
        for (int k = 6; k <= 12; k++) gt[k] = '{1'b0, 16'd0, 1'b0, 1'b1, 16'd0, 1'b1};
        gt[13] = '{1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 1'b0};

        reset = 1'b1;
        s_data = 16'd0; s_valid = 1'b0; s_last = 1'b0;
        coeff_wr_en = 1'b0; coeff_wr_addr = 3'd0; coeff_wr_data = 16'd0;
        sm_s_data = 16'd0; sm_s_valid = 1'b0; sm_s_last = 1'b0;
        sm_wr_en = 1'b0; sm_wr_addr = 3'd0; sm_wr_data = 16'd0;

        cyc(3);
        chk("rst_enable", 128'(enable), 128'd0);
        chk("rst_ready", 128'(s_ready), 128'd0);
        chk("rst_level", 128'(fifo_level), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_err", 128'(coeff_wr_err), 128'd0);
        chk("rst_data", 128'(input_data), 128'd0);
        chk("rst_coeff", coeff, 128'd0);
        reset = 1'b0;
        #1;
        chk("ready_before_edge", 128'(s_ready), 128'd0);
        cyc(1);
        chk("ready_after_edge", 128'(s_ready), 128'd1);

        // Tap loading in IDLE: each write visible one cycle after its strobe
        for (int i = 0; i < 8; i++) begin
            coeff_wr_en = 1'b1; coeff_wr_addr = ct[i].a; coeff_wr_data = ct[i].d;
            cyc(1);
            chk("tap_write", 128'(coeff[ct[i].a*16 +: 16]), 128'(ct[i].exp_tap));
            chk("tap_err", 128'(coeff_wr_err), 128'd0);
        end
        coeff_wr_en = 1'b0;
        cyc(1);
        chk("tap_bus", coeff, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("tap_err_idle", 128'(coeff_wr_err), 128'd0);

        // Frame 10,20,30; a tap write rides on the IDLE->STREAM pop cycle
        base = got_q.size();
        send(16'd10, 1'b0);
        coeff_wr_en = 1'b1; coeff_wr_addr = 3'd0; coeff_wr_data = 16'h00AA;
        send(16'd20, 1'b0);
        coeff_wr_en = 1'b0;
        chk("pop_cycle_tap", 128'(coeff[15:0]), 128'h00AA);
        chk("pop_cycle_err", 128'(coeff_wr_err), 128'd0);
        send(16'd30, 1'b1);
        wait_idle("frame3_idle");
        cyc(2);
        exp_q = '{16'd10, 16'd20, 16'd30};
        for (int k = 0; k < 7; k++) exp_q.push_back(16'd0);
        cmp_stream("frame3", base, exp_q);
        chk("frame3_level", 128'(fifo_level), 128'd0);
        chk("frame3_busy", 128'(busy), 128'd0);
        chk("frame3_enable", 128'(enable), 128'd0);

        // Mid-frame valid gap, cycle-exact
        for (int i = 0; i < 14; i++) begin
            s_valid = gt[i].v; s_data = gt[i].d; s_last = gt[i].l;
            cyc(1);
            chk("gap_enable", 128'(enable), 128'(gt[i].en));
            chk("gap_data", 128'(input_data), 128'(gt[i].q));
            chk("gap_busy", 128'(busy), 128'(gt[i].bz));
        end
        s_valid = 1'b0; s_last = 1'b0;

        // Single-sample frame followed by 12 samples: FIFO fills during FLUSH
        base = got_q.size();
        lbase = lvl_q.size();
        sbase = stall_cnt;
        send(16'd5, 1'b1);
        for (int k = 1; k <= 12; k++) send(16'(k), 1'b0);
        n = 0;
        while (fifo_level != 4'd0 && n < 100) begin cyc(1); n++; end
        chk("fill_drain", 128'(fifo_level), 128'd0);
        cyc(2);
        exp_q = '{16'd5};
        for (int k = 0; k < 7; k++) exp_q.push_back(16'd0);
        for (int k = 1; k <= 12; k++) exp_q.push_back(16'(k));
        cmp_stream("fill", base, exp_q);
        maxl = 0;
        for (int i = lbase; i < lvl_q.size(); i++) if (int'(lvl_q[i]) > maxl) maxl = int'(lvl_q[i]);
        chk("fill_max_level", 128'(maxl), 128'd8);
        chk("fill_stalled", 128'(stall_cnt > sbase), 128'd1);

        // Tap write while streaming is rejected with a single-cycle pulse
        chk("stream_busy", 128'(busy), 128'd1);
        coeff_wr_en = 1'b1; coeff_wr_addr = 3'd2; coeff_wr_data = 16'h7FFF;
        cyc(1);
        coeff_wr_en = 1'b0;
        chk("stream_wr_err", 128'(coeff_wr_err), 128'd1);
        chk("stream_wr_coeff", coeff, 128'h0008_0007_0006_0005_0004_0003_0002_00AA);
        cyc(1);
        chk("stream_wr_err_end", 128'(coeff_wr_err), 128'd0);
        send(16'd99, 1'b1);
        wait_idle("close_idle");
        cyc(2);

        // Out-of-range address on a 6-tap instance
        sm_wr_en = 1'b1; sm_wr_addr = 3'd7; sm_wr_data = 16'h1234;
        cyc(1);
        chk("sm_bad_err", 128'(sm_wr_err), 128'd1);
        chk("sm_bad_coeff", 128'(sm_coeff), 128'd0);
        sm_wr_addr = 3'd5; sm_wr_data = 16'h0055;
        cyc(1);
        chk("sm_good_err", 128'(sm_wr_err), 128'd0);
        chk("sm_good_tap", 128'(sm_coeff[95:80]), 128'h0055);
        sm_wr_en = 1'b0;
        cyc(1);
        chk("sm_err_idle", 128'(sm_wr_err), 128'd0);

        // Reset mid-frame discards everything
        send(16'd1, 1'b0);
        send(16'd2, 1'b0);
        chk("pre_rst_enable", 128'(enable), 128'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_enable", 128'(enable), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_level", 128'(fifo_level), 128'd0);
        chk("mid_rst_coeff", coeff, 128'd0);
        chk("mid_rst_data", 128'(input_data), 128'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(1);
        chk("post_rst_ready", 128'(s_ready), 128'd1);
        base = got_q.size();
        send(16'd100, 1'b0);
        send(16'd200, 1'b1);
        wait_idle("post_rst_idle");
        cyc(2);
        exp_q = '{16'd100, 16'd200};
        for (int k = 0; k < 7; k++) exp_q.push_back(16'd0);
        cmp_stream("post_rst", base, exp_q);
        chk("post_rst_level", 128'(fifo_level), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/convol_stream_source.md
CONVOL_STREAM_SOURCE -- requirements
Module: convol_stream_source

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of each sample.
REQ-002 Parameter COEFF_WIDTH, default 16, width of each tap coefficient.
REQ-003 Parameter NUM_TAPS, default 8, number of kernel taps (>=2).
REQ-004 Parameter FIFO_DEPTH, default 8, sample buffer depth (power of 2, >=2).
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 s_data  in  DATA_WIDTH  upstream sample.
REQ-008 s_valid  in  1  upstream sample valid.
REQ-009 s_last  in  1  marks the last sample of a frame; qualified by s_valid.
REQ-010 s_ready  out  1  block can accept a sample this cycle.
REQ-011 coeff_wr_en  in  1  coefficient write strobe.
REQ-012 coeff_wr_addr  in  $clog2(NUM_TAPS)  tap index to write.
REQ-013 coeff_wr_data  in  COEFF_WIDTH  coefficient value.
REQ-014 coeff_wr_err  out  1  one-cycle pulse: the write was rejected.
REQ-015 input_data  out  DATA_WIDTH  sample to the kernel.
REQ-016 enable  out  1  input_data valid to the kernel.
REQ-017 coeff  out  NUM_TAPS*COEFF_WIDTH  packed taps; tap k at [k*COEFF_WIDTH +: COEFF_WIDTH].
REQ-018 busy  out  1  high in STREAM or FLUSH.
REQ-019 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-020 The FIFO SHALL store {s_data, s_last} and push on s_valid && s_ready, with s_ready = (fifo_level < FIFO_DEPTH) and no full-bypass.
REQ-021 A simultaneous push and pop SHALL leave fifo_level unchanged, and the pushed entry SHALL be preserved in order.
REQ-022 The FSM SHALL have the states IDLE, STREAM and FLUSH.
REQ-023 In IDLE or STREAM with the FIFO non-empty, the block SHALL pop the head, and one clock later drive input_data = head data with enable = 1 (registered outputs).
REQ-024 Popping in IDLE SHALL move the FSM to STREAM.
REQ-025 Minimum latency from a sample push to enable high SHALL be 2 cycles.
REQ-026 In STREAM with the FIFO empty, enable SHALL be 0 and input_data SHALL hold its last value.
REQ-027 Popping an entry with last = 1 SHALL move the FSM to FLUSH and load flush_cnt = NUM_TAPS-1.
REQ-028 In FLUSH, the block SHALL drive input_data = 0 and enable = 1 for exactly NUM_TAPS-1 cycles, with no FIFO pops, then enter IDLE.
REQ-029 FIFO pushes SHALL continue during FLUSH.
REQ-030 After FLUSH, a buffered next frame SHALL be popped on the first IDLE cycle, leaving no extra gap beyond that IDLE cycle.
REQ-031 In IDLE, a coefficient write SHALL update its tap register on the next edge, and the coeff bus SHALL reflect it one cycle after the strobe.
REQ-032 A coefficient write in STREAM or FLUSH, or with coeff_wr_addr >= NUM_TAPS, SHALL be ignored and SHALL pulse coeff_wr_err high for exactly one cycle, registered.
REQ-033 A coefficient write in the same cycle as the IDLE->STREAM pop SHALL be accepted, because the state is still IDLE.
REQ-034 The block SHALL perform no arithmetic on the data, and samples SHALL pass bit-exact.

Reset
REQ-035 While reset is high, the block SHALL force: state IDLE, FIFO empty, fifo_level 0, s_ready 0, enable 0, input_data 0, busy 0, coeff_wr_err 0, all coeff taps 0.
REQ-036 s_ready SHALL rise on the first edge after reset release.
REQ-037 A reset asserted mid-frame SHALL discard all buffered samples and flush_cnt asynchronously; no partial frame SHALL resume after release.

Verification
REQ-038 IDLE, write taps 0..7 = 1..8 on consecutive cycles -> coeff tap k = k+1 one cycle after each write; coeff_wr_err stays 0.
REQ-039 Frame 10,20,30 (s_last on 30), back-to-back -> enable high 10 cycles: 10, 20, 30, then seven 0s; busy then falls; fifo_level ends 0.
REQ-040 Single-sample frame 5 (last), then 12 back-to-back samples 1..12 -> fifo_level reaches 8 during FLUSH; s_ready drops; all 12 samples emerge in order 1..12 after the 7 zeros.
REQ-041 s_valid low for 2 cycles mid-frame (samples 1, 2, gap, 3 last) -> enable low for 2 cycles with input_data held at 2, then 3, then 7 zeros.
REQ-042 Tap write during STREAM (addr 2, data 0x7FFF) -> coeff unchanged; coeff_wr_err high exactly 1 cycle. With NUM_TAPS=6, an IDLE write to addr 7 -> also rejected with an error pulse.
REQ-043 Reset asserted after 2 of 5 samples of a frame -> enable and busy 0 immediately; fifo_level 0; coeff all 0. After release, frame 100,200 (last) -> enable 100, 200, then 7 zeros.
